instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Instruction fetch sequencer. Produces the 32-bit instruction word and its 6-bit opcode field for the opcode decoder.
//  Consumes the decoder's Branch/Jump outputs plus the ALU branch condition to choose the next PC.
//  Sits between instruction memory (req/ack port) and the decode stage (valid/ready port).
// PARAMETERS
//  ADDR_W       32   PC / imem address width; legal range >= 28.
//  RESET_PC     0    PC loaded by reset.
//  TIMEOUT_CYC  255  Max cycles in FETCH without imem_ack before error; 0 disables the timeout.
// PORTS
//  clk          in   1       Clock; rising edge.
//  rst          in   1       Synchronous, active-high reset.
//  imem_req     out  1       Fetch request.
//  imem_addr    out  ADDR_W  Fetch address (= pc_o).
//  imem_ack     in   1       imem_rdata valid this cycle.
//  imem_rdata   in   32      Instruction word.
//  instr_valid  out  1       instr_o holds an unconsumed instruction.
//  instr_ready  in   1       Decode stage accepts instr_o.
//  instr_o      out  32      Current instruction.
//  opcode_o     out  6       Opcode field, instr_o[31:26]; feeds the decoder.
//  pc_o         out  ADDR_W  PC of instr_o / of the fetch in flight.
//  branch_i     in   1       Decoder Branch for instr_o.
//  jump_i       in   1       Decoder Jump for instr_o.
//  cond_i       in   1       ALU branch condition (zero) for instr_o.
//  fetch_err    out  1       Sticky: imem timeout occurred.
// BEHAVIOUR
//  States: S_RST -> S_FETCH -> S_ISSUE -> S_FETCH ...; any -> S_ERR on timeout.
//  - S_RST: entered during rst. Outputs req=0, valid=0, err=0, instr_o=0, pc=RESET_PC. Leaves to S_FETCH in the first cycle after rst falls.
//  - S_FETCH: imem_req=1, imem_addr held stable. On imem_ack, latch rdata and go to S_ISSUE.
//  - S_ISSUE: instr_valid=1. instr_o, opcode_o and pc_o are held stable until instr_valid & instr_ready.
//    On accept: pc <= next_pc and go to S_FETCH.
//  - S_ERR: req=0, valid=0, fetch_err=1. Exited only by rst.
//  Latency: ack in cycle N -> instr_valid in N+1. Accept in cycle M -> imem_req for next PC in M+1. Peak rate is 1 instruction per 2 cycles.
//  ack is accepted in the same cycle req rises. ack outside S_FETCH is ignored, including a stale ack after a mid-fetch reset.
//  next_pc: pc4 = pc+4. Evaluated only at accept:
//    - jump_i: {pc4[ADDR_W-1:28], instr[25:0], 2'b00}.
//    - else branch_i & cond_i: pc4 + {sext(instr[15:0]), 2'b00}.
//    - else: pc4.
//    Jump has priority when jump_i and branch_i are both set. All arithmetic is modulo 2^ADDR_W; wrap from max to 0 is silent.
//  Timeout: the counter clears on entry to S_FETCH and counts each S_FETCH cycle without ack.
//    When it reaches TIMEOUT_CYC: go to S_ERR. An ack arriving in that same cycle wins; no error is raised.
//  Reset mid-operation: any state -> S_RST next edge; the pending instruction is discarded.
// CONFIGURATION
//  FETCH_DELAY_SLOT_EN defined:
//    - A taken redirect is stored in a pending-target register. The next fetch uses pc4 (the delay slot).
//    - On accept of the slot instruction, pc <= pending target and the pending register clears.
//    - branch_i/jump_i presented with the slot instruction are ignored.
//    - rst clears the pending register.
//  FETCH_DELAY_SLOT_EN undefined: redirect applies immediately to the next fetch; no pending register exists.
// STRUCTURE
//  Package fetch_pkg holds:
//    - state typedef (S_RST, S_FETCH, S_ISSUE, S_ERR);
//    - INSTR_W=32, OPC_MSB=31, OPC_LSB=26, IMM_W=16, JIDX_W=26;
//    - opcode constants OP_RTYPE=0, OP_J=2, OP_ADDI=8.
//  Sub-module fetch_next_pc: pure combinational next-PC/target computation; unit-testable alone.
// TESTING
//  1. rst 3 cycles, release; ack after 2 cycles with 0x20080005
//     -> imem_addr=RESET_PC; valid 1 cycle after ack; opcode_o=8; next addr=0x4.
//  2. Hold instr_ready=0 for 5 cycles -> instr_o/pc_o stable, no new imem_req; ready=1 -> req next cycle.
//  3. pc=0x100, instr=0x1000FFFF, branch_i=1, cond_i=1 -> next addr 0x100. Same with cond_i=0 -> 0x104.
//  4. pc=0x4000_0000, instr=0x08000010, jump_i=1 -> next addr 0x4000_0040.
//     With FETCH_DELAY_SLOT_EN: 0x4000_0004 first, then 0x4000_0040.
//  5. TIMEOUT_CYC=4, never ack -> fetch_err=1 after 4 FETCH cycles; req drops; rst clears fetch_err.
//  6. rst mid-fetch, then ack arriving during rst -> ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and field constants for the instruction fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_RST   = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  localparam int INSTR_W = 32;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int IMM_W   = 16;
  localparam int JIDX_W  = 26;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_ADDI  = 6'd8;

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC calculation: sequential pc+4, jump region target,
// and pc-relative branch target; reports whether a redirect is taken.
module fetch_next_pc
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [JIDX_W-1:0] i_jidx,
  input  logic              i_branch,
  input  logic              i_jump,
  input  logic              i_cond,
  output logic [ADDR_W-1:0] o_pc4,
  output logic [ADDR_W-1:0] o_target,
  output logic              o_taken
);

  logic [ADDR_W-1:0] w_boff;
  logic [ADDR_W-1:0] w_jtgt;

  assign o_pc4  = i_pc + ADDR_W'(4);
  assign w_boff = {{(ADDR_W-IMM_W-2){i_jidx[IMM_W-1]}}, i_jidx[IMM_W-1:0], 2'b00};

  // The jump keeps the region bits of pc+4 above the 28-bit jump reach.
  if (ADDR_W > JIDX_W + 2) begin : g_region
    assign w_jtgt = {o_pc4[ADDR_W-1:JIDX_W+2], i_jidx, 2'b00};
  end else begin : g_noregion
    assign w_jtgt = {i_jidx, 2'b00};
  end

  assign o_target = i_jump ? w_jtgt : (o_pc4 + w_boff);
  assign o_taken  = i_jump | (i_branch & i_cond);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer between imem (req/ack) and decode (valid/ready).
// Optional build macro FETCH_DELAY_SLOT_EN defers taken redirects by one slot.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_o,
  output logic [5:0]         opcode_o,
  output logic [ADDR_W-1:0]  pc_o,
  input  logic               branch_i,
  input  logic               jump_i,
  input  logic               cond_i,
  output logic               fetch_err
);

  localparam int                TMO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDR_W-1:0]  r_pc;
  logic [INSTR_W-1:0] r_instr;
  logic [TMO_W-1:0]   r_tmo;

  logic               w_accept;
  logic               w_tmo_hit;
  logic [ADDR_W-1:0]  w_pc4;
  logic [ADDR_W-1:0]  w_target;
  logic               w_taken;
  logic [ADDR_W-1:0]  w_pc_nxt;

  assign w_accept  = (r_state == S_ISSUE) && instr_ready;
  assign w_tmo_hit = (TIMEOUT_CYC != 0) && (r_tmo == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_RST;
    else     r_state <= w_state_nxt;
  end

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no path through the case can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_RST:   w_state_nxt = S_FETCH;
      S_FETCH: begin
        if (imem_ack)       w_state_nxt = S_ISSUE;
        else if (w_tmo_hit) w_state_nxt = S_ERR;
      end
      S_ISSUE: if (instr_ready) w_state_nxt = S_FETCH;
      S_ERR:   w_state_nxt = S_ERR;
      default: w_state_nxt = S_RST;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    fetch_err   = 1'b0;
    unique case (r_state)
      S_FETCH: imem_req    = 1'b1;
      S_ISSUE: instr_valid = 1'b1;
      S_ERR:   fetch_err   = 1'b1;
      default: ;
    endcase
  end

  // The timeout counter is held at zero outside FETCH, so it restarts on entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_instr <= '0;
      r_tmo   <= '0;
    end else begin
      if ((r_state == S_FETCH) && imem_ack) r_instr <= imem_rdata;
      if (w_accept)                         r_pc    <= w_pc_nxt;
      if ((r_state == S_FETCH) && !imem_ack) r_tmo  <= r_tmo + 1'b1;
      else                                   r_tmo  <= '0;
    end
  end

  fetch_next_pc #(
    .ADDR_W (ADDR_W)
  ) u_next_pc (
    .i_pc     (r_pc),
    .i_jidx   (r_instr[JIDX_W-1:0]),
    .i_branch (branch_i),
    .i_jump   (jump_i),
    .i_cond   (cond_i),
    .o_pc4    (w_pc4),
    .o_target (w_target),
    .o_taken  (w_taken)
  );

`ifdef FETCH_DELAY_SLOT_EN
  logic              r_pend_vld;
  logic [ADDR_W-1:0] r_pend_tgt;

  // NOTE: only the valid flag is reset; the target is never read while the
  // flag is clear, so it stays a plain datapath register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_vld <= 1'b0;
    end else if (w_accept) begin
      if (r_pend_vld) begin
        r_pend_vld <= 1'b0;
      end else if (w_taken) begin
        r_pend_vld <= 1'b1;
        r_pend_tgt <= w_target;
      end
    end
  end

  // The slot instruction's own branch/jump flags never reach the PC.
  assign w_pc_nxt = r_pend_vld ? r_pend_tgt : w_pc4;
`else
  assign w_pc_nxt = w_taken ? w_target : w_pc4;
`endif

  assign imem_addr = r_pc;
  assign pc_o      = r_pc;
  assign instr_o   = r_instr;
  assign opcode_o  = r_instr[OPC_MSB:OPC_LSB];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit (RESET_PC=0x4000_0000,
// TIMEOUT_CYC=4); honours FETCH_DELAY_SLOT_EN when the build defines it.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_o;
  logic [5:0]  opcode_o;
  logic [31:0] pc_o;
  logic        branch_i;
  logic        jump_i;
  logic        cond_i;
  logic        fetch_err;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .ADDR_W      (32),
    .RESET_PC    (32'h4000_0000),
    .TIMEOUT_CYC (4)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_o     (instr_o),
    .opcode_o    (opcode_o),
    .pc_o        (pc_o),
    .branch_i    (branch_i),
    .jump_i      (jump_i),
    .cond_i      (cond_i),
    .fetch_err   (fetch_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for a request, check its address, ack after 'delay' idle cycles.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] word, input int delay);
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_up", 32'(imem_req), 32'd1);
    check("fetch_addr", imem_addr, addr);
    repeat (delay) @(negedge clk);
    check("addr_hold", imem_addr, addr);
    imem_ack   = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = '0;
    check("valid_after_ack", 32'(instr_valid), 32'd1);
    check("instr", instr_o, word);
    check("pc", pc_o, addr);
  endtask

  task automatic accept(input logic br, input logic jp, input logic cd);
    instr_ready = 1'b1;
    branch_i    = br;
    jump_i      = jp;
    cond_i      = cd;
    @(negedge clk);
    instr_ready = 1'b0;
    branch_i    = 1'b0;
    jump_i      = 1'b0;
    cond_i      = 1'b0;
    check("req_after_accept", 32'(imem_req), 32'd1);
    check("valid_drop", 32'(instr_valid), 32'd0);
  endtask

  // With a delay slot, a taken redirect first fetches pc+4; the slot carries
  // a jump flag that must be ignored.
  task automatic slot(input logic [31:0] addr);
`ifdef FETCH_DELAY_SLOT_EN
    fetch(addr, 32'h0800_0001, 0);
    accept(1'b0, 1'b1, 1'b0);
`else
    if (addr[1:0] != 2'b00) $display("slot address misaligned %h", addr);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    imem_ack    = 1'b0;
    imem_rdata  = '0;
    instr_ready = 1'b0;
    branch_i    = 1'b0;
    jump_i      = 1'b0;
    cond_i      = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_err", 32'(fetch_err), 32'd0);
    check("rst_instr", instr_o, 32'd0);
    check("rst_pc", pc_o, 32'h4000_0000);

    // First fetch: ADDI, ack after two idle cycles, sequential next PC
    rst = 1'b0;
    @(negedge clk);
    check("req_first_cycle", 32'(imem_req), 32'd1);
    fetch(32'h4000_0000, 32'h2008_0005, 2);
    check("opcode_addi", 32'(opcode_o), 32'd8);
    accept(1'b0, 1'b0, 1'b0);

    // Back-pressure: outputs hold, no new request
    fetch(32'h4000_0004, 32'h0800_0010, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_instr", instr_o, 32'h0800_0010);
      check("hold_pc", pc_o, 32'h4000_0004);
      check("hold_noreq", 32'(imem_req), 32'd0);
      check("hold_valid", 32'(instr_valid), 32'd1);
    end
    check("opcode_j", 32'(opcode_o), 32'd2);
    accept(1'b0, 1'b1, 1'b0);
    slot(32'h4000_0008);

    // Jump landed at region 4 + 0x40; ack on the timeout cycle wins
    fetch(32'h4000_0040, 32'h1000_FFFF, 3);
    check("ack_wins_no_err", 32'(fetch_err), 32'd0);
    accept(1'b1, 1'b0, 1'b1);
    slot(32'h4000_0044);

    // Branch back to itself, then not taken
    fetch(32'h4000_0040, 32'h1000_FFFF, 0);
    accept(1'b1, 1'b0, 1'b0);

    // Forward branch: 0x4000_0048 + 12
    fetch(32'h4000_0044, 32'h1000_0003, 1);
    accept(1'b1, 1'b0, 1'b1);
    slot(32'h4000_0048);

    // Jump beats branch when both are set
    fetch(32'h4000_0054, 32'h0800_0100, 0);
    accept(1'b1, 1'b1, 1'b1);
    slot(32'h4000_0058);

    // Timeout: never ack
    check("tmo_req", 32'(imem_req), 32'd1);
    check("tmo_addr", imem_addr, 32'h4000_0400);
    repeat (3) @(negedge clk);
    check("tmo_err_early", 32'(fetch_err), 32'd0);
    check("tmo_req_early", 32'(imem_req), 32'd1);
    @(negedge clk);
    check("tmo_err", 32'(fetch_err), 32'd1);
    check("tmo_req_drop", 32'(imem_req), 32'd0);
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    check("err_sticky", 32'(fetch_err), 32'd1);
    check("err_no_valid", 32'(instr_valid), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("err_cleared", 32'(fetch_err), 32'd0);
    check("err_rst_req", 32'(imem_req), 32'd0);

    // Reset mid-fetch with a stale ack during reset
    rst = 1'b0;
    @(negedge clk);
    check("refetch_req", 32'(imem_req), 32'd1);
    check("refetch_addr", imem_addr, 32'h4000_0000);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("stale_valid", 32'(instr_valid), 32'd0);
    check("stale_req", 32'(imem_req), 32'd0);
    check("stale_instr", instr_o, 32'd0);
    imem_ack   = 1'b0;
    imem_rdata = '0;
    rst        = 1'b0;
    @(negedge clk);
    check("restart_addr", imem_addr, 32'h4000_0000);
    fetch(32'h4000_0000, 32'h0000_0020, 0);
    check("opcode_rtype", 32'(opcode_o), 32'd0);

    // Reset while an instruction is pending discards it
    rst = 1'b1;
    @(negedge clk);
    check("discard_valid", 32'(instr_valid), 32'd0);
    check("discard_instr", instr_o, 32'd0);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
